// File: rtl/regfile_pkg.sv
`default_nettype none
// ============================================================================
// regfile_pkg : shared sizes and encodings for the register-file writeback
//               scheduler
// Revision    : 1.0
// ============================================================================
package regfile_pkg;

    localparam int NREG  = 16;
    localparam int DW    = 18;
    localparam int SEL_W = 4;

    typedef enum logic [0:0] {
        CLR = 1'b0,
        RUN = 1'b1
    } state_t;

    typedef enum logic [0:0] {
        SRC_A = 1'b0,
        SRC_M = 1'b1
    } src_t;

endpackage
`default_nettype wire

// File: rtl/wb_rr_arbiter.sv
`default_nettype none
// ============================================================================
// wb_rr_arbiter : 2-way round-robin grant between ALU and load writeback
// Revision      : 1.0
// ============================================================================
module wb_rr_arbiter
    import regfile_pkg::*;
(
    input  logic AValid,
    input  logic MValid,
    input  src_t LastGrant,
    output logic GrantA,
    output logic GrantM
);

    // Under contention the source that did not win last time is favoured.
    assign GrantA = AValid && (!MValid || (LastGrant == SRC_M));
    assign GrantM = MValid && (!AValid || (LastGrant == SRC_A));

endmodule
`default_nettype wire

// File: rtl/regfile_wb_scheduler.sv
`default_nettype none
// ============================================================================
// regfile_wb_scheduler : shares the register-file write port between ALU and
//                        load writeback, runs the zero-clear, tracks hazards
// Revision             : 1.0
// ============================================================================
module regfile_wb_scheduler #(
    parameter int NREG = regfile_pkg::NREG,
    parameter int DW   = regfile_pkg::DW
) (
    input  logic                    Clock,
    input  logic                    ClearN,
    input  logic                    ClearReq,
    input  logic                    AValid,
    output logic                    AReady,
    input  logic [$clog2(NREG)-1:0] ASel,
    input  logic [DW-1:0]           AData,
    input  logic                    MValid,
    output logic                    MReady,
    input  logic [$clog2(NREG)-1:0] MSel,
    input  logic [DW-1:0]           MData,
    input  logic                    ResvValid,
    input  logic [$clog2(NREG)-1:0] ResvSel,
    input  logic [$clog2(NREG)-1:0] ReadSelect1,
    input  logic [$clog2(NREG)-1:0] ReadSelect2,
    output logic                    Stall,
    output logic [$clog2(NREG)-1:0] WriteSelect,
    output logic [DW-1:0]           WriteData,
    output logic                    WriteEnable,
    output logic                    Busy,
    output logic [NREG-1:0]         PendingMask
);

    import regfile_pkg::state_t;
    import regfile_pkg::src_t;
    import regfile_pkg::CLR;
    import regfile_pkg::RUN;
    import regfile_pkg::SRC_A;
    import regfile_pkg::SRC_M;

    localparam int SELW = $clog2(NREG);
    localparam logic [SELW-1:0] LAST_SEL = SELW'(NREG - 1);

    state_t            r_state;
    src_t              r_lastGrant;
    logic [SELW-1:0]   r_counter;
    logic [SELW-1:0]   r_writeSelect;
    logic [DW-1:0]     r_writeData;
    logic              r_writeEnable;
    logic              r_busy;
    logic [NREG-1:0]   r_pendingMask;

    logic              w_grantA;
    logic              w_grantM;
    logic              w_xferA;
    logic              w_xferM;
    logic [NREG-1:0]   w_setMask;
    logic [NREG-1:0]   w_clrMask;

    wb_rr_arbiter u_arb (
        .AValid    (AValid),
        .MValid    (MValid),
        .LastGrant (r_lastGrant),
        .GrantA    (w_grantA),
        .GrantM    (w_grantM)
    );

    assign AReady  = (r_state == RUN) && !ClearReq && w_grantA;
    assign MReady  = (r_state == RUN) && !ClearReq && w_grantM;
    assign w_xferA = AValid && AReady;
    assign w_xferM = MValid && MReady;

    assign w_setMask = ResvValid     ? (NREG'(1) << ResvSel)       : '0;
    assign w_clrMask = r_writeEnable ? (NREG'(1) << r_writeSelect) : '0;

    assign Stall       = r_pendingMask[ReadSelect1] | r_pendingMask[ReadSelect2];
    assign WriteSelect = r_writeSelect;
    assign WriteData   = r_writeData;
    assign WriteEnable = r_writeEnable;
    assign Busy        = r_busy;
    assign PendingMask = r_pendingMask;

    always_ff @(posedge Clock or negedge ClearN) begin
        if (!ClearN) begin
            r_state       <= CLR;
            r_lastGrant   <= SRC_M;
            r_counter     <= '0;
            r_writeSelect <= '0;
            r_writeData   <= '0;
            r_writeEnable <= 1'b0;
            r_busy        <= 1'b1;
            r_pendingMask <= '0;
        end else begin
            case (r_state)
                CLR: begin
                    r_pendingMask <= '0;
                    // Leave once the last zero-write has been presented for a cycle.
                    if (r_writeEnable && (r_writeSelect == LAST_SEL)) begin
                        r_state       <= RUN;
                        r_busy        <= 1'b0;
                        r_writeEnable <= 1'b0;
                    end else begin
                        r_writeEnable <= 1'b1;
                        r_writeSelect <= r_counter;
                        r_writeData   <= '0;
                        r_counter     <= (r_counter == LAST_SEL) ? '0 : r_counter + 1'b1;
                    end
                end
                default: begin
                    if (ClearReq) begin
                        r_state       <= CLR;
                        r_busy        <= 1'b1;
                        r_counter     <= '0;
                        r_pendingMask <= '0;
                        r_writeEnable <= 1'b0;
                    end else begin
                        // Reservation takes priority over a same-cycle retire.
                        r_pendingMask <= (r_pendingMask & ~w_clrMask) | w_setMask;
                        if (w_xferA) begin
                            r_writeEnable <= 1'b1;
                            r_writeSelect <= ASel;
                            r_writeData   <= AData;
                            r_lastGrant   <= SRC_A;
                        end else if (w_xferM) begin
                            r_writeEnable <= 1'b1;
                            r_writeSelect <= MSel;
                            r_writeData   <= MData;
                            r_lastGrant   <= SRC_M;
                        end else begin
                            r_writeEnable <= 1'b0;
                        end
                    end
                end
            endcase
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_regfile_wb_scheduler.sv
`default_nettype none
// ============================================================================
// tb_regfile_wb_scheduler : directed self-checking bench for the scheduler
// Revision                : 1.0
// ============================================================================
module tb_regfile_wb_scheduler;

    logic        Clock;
    logic        ClearN;
    logic        ClearReq;
    logic        AValid;
    logic        AReady;
    logic [3:0]  ASel;
    logic [17:0] AData;
    logic        MValid;
    logic        MReady;
    logic [3:0]  MSel;
    logic [17:0] MData;
    logic        ResvValid;
    logic [3:0]  ResvSel;
    logic [3:0]  ReadSelect1;
    logic [3:0]  ReadSelect2;
    logic        Stall;
    logic [3:0]  WriteSelect;
    logic [17:0] WriteData;
    logic        WriteEnable;
    logic        Busy;
    logic [15:0] PendingMask;

    int vectors    = 0;
    int miscompares = 0;

    regfile_wb_scheduler #(.NREG(16), .DW(18)) dut (
        .Clock       (Clock),
        .ClearN      (ClearN),
        .ClearReq    (ClearReq),
        .AValid      (AValid),
        .AReady      (AReady),
        .ASel        (ASel),
        .AData       (AData),
        .MValid      (MValid),
        .MReady      (MReady),
        .MSel        (MSel),
        .MData       (MData),
        .ResvValid   (ResvValid),
        .ResvSel     (ResvSel),
        .ReadSelect1 (ReadSelect1),
        .ReadSelect2 (ReadSelect2),
        .Stall       (Stall),
        .WriteSelect (WriteSelect),
        .WriteData   (WriteData),
        .WriteEnable (WriteEnable),
        .Busy        (Busy),
        .PendingMask (PendingMask)
    );

    initial Clock = 1'b0;
    always #5 Clock = ~Clock;

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        vectors++;
        assert (obs === exp) else begin
            miscompares++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(negedge Clock);
    endtask

    task automatic check_reset_values(input string tag);
        chk({tag, ".we"},    32'(WriteEnable), 32'd0);
        chk({tag, ".ws"},    32'(WriteSelect), 32'd0);
        chk({tag, ".wd"},    32'(WriteData),   32'd0);
        chk({tag, ".busy"},  32'(Busy),        32'd1);
        chk({tag, ".mask"},  32'(PendingMask), 32'd0);
        chk({tag, ".aRdy"},  32'(AReady),      32'd0);
        chk({tag, ".mRdy"},  32'(MReady),      32'd0);
        chk({tag, ".stall"}, 32'(Stall),       32'd0);
    endtask

    // Expects the cycle after the current negedge to be the first zero-write.
    task automatic check_clear_sequence(input string tag);
        for (int i = 0; i < 16; i++) begin
            tick();
            chk({tag, ".we"},   32'(WriteEnable), 32'd1);
            chk({tag, ".ws"},   32'(WriteSelect), 32'(i));
            chk({tag, ".wd"},   32'(WriteData),   32'd0);
            chk({tag, ".busy"}, 32'(Busy),        32'd1);
            chk({tag, ".aRdy"}, 32'(AReady),      32'd0);
            chk({tag, ".mRdy"}, 32'(MReady),      32'd0);
        end
        tick();
        chk({tag, ".endWe"},   32'(WriteEnable), 32'd0);
        chk({tag, ".endBusy"}, 32'(Busy),        32'd0);
        chk({tag, ".endMask"}, 32'(PendingMask), 32'd0);
    endtask

    initial begin
        ClearN = 1'b0; ClearReq = 1'b0;
        AValid = 1'b0; ASel = 4'd0; AData = '0;
        MValid = 1'b0; MSel = 4'd0; MData = '0;
        ResvValid = 1'b0; ResvSel = 4'd0;
        ReadSelect1 = 4'd0; ReadSelect2 = 4'd0;

        tick(); tick();
        check_reset_values("reset");

        // Sources contend throughout the clear: no ready until RUN.
        AValid = 1'b1; ASel = 4'd3; AData = 18'h00011;
        MValid = 1'b1; MSel = 4'd5; MData = 18'h3FFFF;
        ClearN = 1'b1;
        check_clear_sequence("init");

        // First RUN cycle: LastGrant = M after reset, so A wins first.
        chk("cont.aRdy0", 32'(AReady), 32'd1);
        chk("cont.mRdy0", 32'(MReady), 32'd0);
        for (int i = 0; i < 4; i++) begin
            tick();
            chk("cont.we", 32'(WriteEnable), 32'd1);
            chk("cont.ws", 32'(WriteSelect), (i % 2 == 0) ? 32'd3 : 32'd5);
            chk("cont.wd", 32'(WriteData),   (i % 2 == 0) ? 32'h00011 : 32'h3FFFF);
            chk("cont.aRdy", 32'(AReady), (i % 2 == 0) ? 32'd0 : 32'd1);
            chk("cont.mRdy", 32'(MReady), (i % 2 == 0) ? 32'd1 : 32'd0);
        end
        AValid = 1'b0; MValid = 1'b0;

        tick();
        chk("idle.we", 32'(WriteEnable), 32'd0);
        ResvValid = 1'b1; ResvSel = 4'd7; ReadSelect1 = 4'd7;

        tick();
        ResvValid = 1'b0;
        chk("sb.mask7",  32'(PendingMask), 32'h0080);
        chk("sb.stall1", 32'(Stall),       32'd1);
        MValid = 1'b1; MSel = 4'd7; MData = 18'h2A5A5;
        #1;
        chk("sb.mRdy", 32'(MReady), 32'd1);

        tick();
        MValid = 1'b0;
        chk("sb.we",       32'(WriteEnable), 32'd1);
        chk("sb.ws",       32'(WriteSelect), 32'd7);
        chk("sb.wd",       32'(WriteData),   32'h2A5A5);
        chk("sb.stallWe",  32'(Stall),       32'd1);

        tick();
        chk("sb.stallAfter", 32'(Stall),       32'd0);
        chk("sb.maskAfter",  32'(PendingMask), 32'd0);
        chk("sb.weAfter",    32'(WriteEnable), 32'd0);
        AValid = 1'b1; ASel = 4'd4; AData = 18'h00123;

        tick();
        AValid = 1'b0;
        chk("sc.we", 32'(WriteEnable), 32'd1);
        chk("sc.ws", 32'(WriteSelect), 32'd4);
        ResvValid = 1'b1; ResvSel = 4'd4;

        tick();
        ResvValid = 1'b0;
        chk("sc.mask4", 32'(PendingMask), 32'h0010);
        ReadSelect2 = 4'd4;
        #1;
        chk("sc.stall", 32'(Stall), 32'd1);

        // ClearReq blocks the grant even though A is the only requester.
        AValid = 1'b1; ASel = 4'd9; AData = 18'h00ABC; ClearReq = 1'b1;
        #1;
        chk("creq.aRdy", 32'(AReady), 32'd0);

        tick();
        ClearReq = 1'b0;
        chk("creq.busy",  32'(Busy),        32'd1);
        chk("creq.mask",  32'(PendingMask), 32'd0);
        chk("creq.we",    32'(WriteEnable), 32'd0);
        chk("creq.stall", 32'(Stall),       32'd0);
        check_clear_sequence("creq");
        AValid = 1'b0;

        // Restart a clear, then abort it with ClearN at step 9.
        ClearReq = 1'b1;
        tick();
        ClearReq = 1'b0;
        chk("abort.busy", 32'(Busy), 32'd1);
        for (int i = 0; i < 10; i++) begin
            tick();
            chk("abort.ws", 32'(WriteSelect), 32'(i));
        end
        ClearN = 1'b0;
        #1;
        check_reset_values("abort");
        tick();
        check_reset_values("abortHeld");
        ClearN = 1'b1;
        check_clear_sequence("restart");

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/regfile_wb_scheduler.md
# regfile_wb_scheduler

Write-port scheduler and scoreboard for the 16 x 18-bit register file. Two writeback sources share the file's single write port: the ALU result path (A) and the memory-load path (M). The block arbitrates between them round-robin and sequences a full zero-clear of all 16 registers after reset or on request. It also tracks pending destination registers so decode can stall on read-after-write hazards.

## Interface
Parameters:
- NREG, 16, number of registers (select width = 4).
- DW, 18, data width.

Ports:
- Clock  in  1  single clock, rising edge.
- ClearN  in  1  reset, asynchronous, active-low.
- ClearReq  in  1  synchronous one-cycle request to re-zero the register file.
- AValid / AReady  in / out  1 / 1  ALU writeback handshake.
- ASel / AData  in  4 / 18  ALU destination register and data.
- MValid / MReady  in / out  1 / 1  load writeback handshake.
- MSel / MData  in  4 / 18  load destination register and data.
- ResvValid / ResvSel  in  1 / 4  decode reserves a destination register.
- ReadSelect1 / ReadSelect2  in  4 / 4  decode source registers.
- Stall  out  1  hazard on either source register.
- WriteSelect / WriteData / WriteEnable  out  4 / 18 / 1  to the register file, all registered.
- Busy  out  1  clear sequence in progress.
- PendingMask  out  16  scoreboard; bit i set means a write to register i is outstanding.

## Operation
- States: CLR and RUN. ClearN low forces CLR, counter = 0, PendingMask = 0, LastGrant = M.
- **CLR:**
  - Each cycle drive WriteEnable = 1, WriteSelect = counter, WriteData = 0, then increment the counter.
  - After select 15 is issued, the counter wraps to 0 and the state moves to RUN.
  - AReady and MReady stay 0. ResvValid is ignored.
- **RUN, arbitration:**
  - If exactly one of AValid/MValid is high, that source is granted.
  - If both are high, the source that was not LastGrant is granted. LastGrant updates on every accepted transfer.
  - XReady = state==RUN && !ClearReq && granted(X), combinational. A transfer occurs when XValid && XReady.
  - An accepted transfer registers WriteSelect/WriteData and WriteEnable = 1 on the next edge. With no transfer, WriteEnable = 0 on the next edge.
- **Scoreboard:**
  - ResvValid sets PendingMask[ResvSel].
  - A cycle with WriteEnable = 1 in RUN clears PendingMask[WriteSelect] at that cycle's closing edge.
  - If a set and a clear target the same bit in the same cycle, set wins.
  - Writes to non-pending registers are legal and leave the mask unchanged.
- **Stall** (combinational) = PendingMask[ReadSelect1] | PendingMask[ReadSelect2].
- **ClearReq in RUN:**
  - No grant in that cycle.
  - A write already registered (WriteEnable high) still completes this cycle.
  - Next edge: state becomes CLR, PendingMask = 0, counter = 0.
  - ClearReq during CLR is ignored.
- Data is passed through unmodified, with no width conversion. Select 0 is an ordinary register.

## Timing
- Reset values:
  - WriteEnable 0, WriteSelect 0, WriteData 0.
  - Busy 1, PendingMask 0.
  - AReady 0, MReady 0, Stall 0.
- Clear sequence: first edge after ClearN rises issues select 0. Sixteen consecutive WriteEnable cycles cover selects 0..15. Busy falls on the edge that enters RUN, which is also the edge WriteEnable drops. First grant is possible in the first RUN cycle.
- Writeback latency: acceptance edge to WriteEnable = 1 cycle. Sustained throughput is 1 write per cycle.
- Busy is registered and equals (state==CLR).
- ClearN asserted mid-sequence or mid-transfer aborts immediately. Any registered write is dropped, and the full clear restarts on release.

## Structure
- Shared package regfile_pkg:
  - NREG, DW, SEL_W = 4.
  - State enum {CLR, RUN}.
  - Source encoding SRC_A / SRC_M.
- One sub-module, wb_rr_arbiter: 2-way round-robin grant from the valids and LastGrant, purely combinational, with the LastGrant register in the parent.
- The scoreboard and clear counter live in the top.

## Test plan
- Reset release: 16 cycles of WriteEnable with WriteSelect 0..15 and WriteData 0, then Busy = 0; no ready during the sequence.
- Contention:
  - AValid = MValid = 1 continuously, with ASel 3 / AData 0x00011 and MSel 5 / MData 0x3FFFF.
  - Required: grants alternate M-first? No — after reset LastGrant = M, so the first grant is A, then M, then A. WriteEnable stays high every cycle with matching select/data one cycle later.
- Scoreboard:
  - ResvValid with ResvSel 7, then ReadSelect1 = 7 gives Stall = 1.
  - An M write to 7 gives Stall = 1 during its WriteEnable cycle and Stall = 0 the cycle after.
- Simultaneous set and clear: ResvSel 4 in the same cycle as the WriteEnable for select 4 leaves PendingMask[4] = 1.
- ClearReq while AValid is high: AReady = 0 that cycle, then Busy = 1 and 16 zero-writes follow, with PendingMask = 0.
- ClearN pulsed low during clear step 9: outputs return to reset values, and the sequence restarts at select 0.
